// File: rtl/lsu_mem_port.sv
// Core load/store port: checks a request, issues one memory access and returns a masked/extended response.
// Latency 1+MEM_LATENCY cycles (1 on error); req_ready only when idle; the response is held until resp_ready.
module lsu_mem_port #(
  parameter int unsigned MEM_LIMIT   = 64,
  parameter int unsigned I_MEM_SIZE  = 32,
  parameter int unsigned IO_ADDR     = 128,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sz_ex,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  localparam logic [31:0]   MEM_LIMIT_A = 32'(MEM_LIMIT);
  localparam logic [31:0]   I_MEM_A     = 32'(I_MEM_SIZE);
  localparam logic [31:0]   IO_A        = 32'(IO_ADDR);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic          req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          mem_wr_en_q, mem_sz_ex_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [1:0]    mem_size_q;
  logic          we_q, sext_q;
  logic [1:0]    size_q;
  logic [CW-1:0] cnt_q;

  logic        is_io, is_imem, acc_err, done;
  logic [31:0] load_d;

  always_comb begin
    is_io   = (req_addr == IO_A);
    is_imem = (req_addr < I_MEM_A);
    acc_err = (req_size == 2'b11)
           || ((req_size == 2'b01) && req_addr[0])
           || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
           || (!(req_addr < MEM_LIMIT_A) && !is_io)
           || (req_we && is_imem);
    done    = ((state_q == ISSUE) && (MEM_LATENCY == 1))
           || ((state_q == WAIT) && (cnt_q == WAIT_LAST));
  end

  // Memory returns right-aligned data; only masking and extension happen here.
  always_comb begin
    case (size_q)
      2'b00:   load_d = {{24{sext_q & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   load_d = {{16{sext_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_d = mem_rdata;
    endcase
    if (we_q) load_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
      mem_sz_ex_q  <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= '0;
      sext_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          size_q      <= req_size;
          sext_q      <= req_sext;
          req_ready_q <= 1'b0;
          if (acc_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q     <= ISSUE;
            mem_wr_en_q <= req_we;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
            // IO and instruction space are always accessed as whole words.
            mem_size_q  <= (is_io || is_imem) ? 2'b10 : req_size;
            mem_sz_ex_q <= (is_io || is_imem) ? 1'b0 : req_sext;
          end
        end
        ISSUE: begin
          mem_wr_en_q <= 1'b0;
          if (!done) begin
            state_q <= WAIT;
            cnt_q   <= CW'(1);
          end
        end
        WAIT: if (!done) cnt_q <= cnt_q + 1'b1;
        RESP: if (resp_ready) begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
      if (done) begin
        state_q      <= RESP;
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= load_d;
        cnt_q        <= '0;
        mem_addr_q   <= '0;
        mem_wdata_q  <= '0;
        mem_size_q   <= '0;
        mem_sz_ex_q  <= 1'b0;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_size   = mem_size_q;
  assign mem_sz_ex  = mem_sz_ex_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a byte-array memory on the mem_* side (data valid only in the capture cycle)
// and an independent golden memory that predicts every response.
module tb_lsu_mem_port;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_we, req_sext, resp_valid, resp_ready, resp_err;
  logic mem_wr_en, mem_sz_ex;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  req_size, mem_size;

  always #5 clk = ~clk;

  lsu_mem_port #(.MEM_LIMIT(64), .I_MEM_SIZE(32), .IO_ADDR(128), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_sz_ex(mem_sz_ex), .mem_rdata(mem_rdata));

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:67];
  logic [31:0] io_reg, junk;
  int          cyc = 0;
  logic [7:0]  gold [0:67];
  logic [31:0] gold_io;

  int          obs_lat, obs_pulses;
  logic [31:0] obs_rdata, obs_maddr;
  logic [1:0]  obs_msize;
  logic        obs_err, obs_szex, obs_rdy_resp;

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] a);
    int b;
    if (a == 32'd128) return io_reg;
    if (a >= 32'd64) return 32'h0;
    b = int'(a[5:0]);
    return {ram[b+3], ram[b+2], ram[b+1], ram[b]};
  endfunction

  // Memory environment: read data shows up only in the cycle ML after the accept edge.
  always @(posedge clk) begin
    junk <= $urandom;
    if (req_valid && req_ready) cyc <= 1;
    else if (cyc < 1000) cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 68; i++) ram[i] <= init_byte(i);
      io_reg <= '0;
    end else if (mem_wr_en) begin
      if (mem_addr == 32'd128) begin
        io_reg[7:0] <= mem_wdata[7:0];
        if (mem_size != 2'b00) io_reg[15:8] <= mem_wdata[15:8];
        if (mem_size == 2'b10) io_reg[31:16] <= mem_wdata[31:16];
      end else if (mem_addr < 32'd64) begin
        ram[int'(mem_addr[5:0])] <= mem_wdata[7:0];
        if (mem_size != 2'b00) ram[int'(mem_addr[5:0]) + 1] <= mem_wdata[15:8];
        if (mem_size == 2'b10) begin
          ram[int'(mem_addr[5:0]) + 2] <= mem_wdata[23:16];
          ram[int'(mem_addr[5:0]) + 3] <= mem_wdata[31:24];
        end
      end
    end
  end

  always_comb mem_rdata = (cyc == ML) ? mem_read(mem_addr) : junk;

  task automatic init_gold();
    for (int i = 0; i < 68; i++) gold[i] = init_byte(i);
    gold_io = '0;
  endtask

  task automatic gold_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int n, b;
    if (a == 32'd128) begin
      gold_io = wd;
      return;
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    b = int'(a[5:0]);
    for (int k = 0; k < n; k++) gold[b+k] = 8'(wd >> (8 * k));
  endtask

  function automatic logic [31:0] exp_load(logic [31:0] a, logic [1:0] sz, logic sx);
    logic [31:0] w;
    int v, b;
    if (a == 32'd128) w = gold_io;
    else begin
      b = int'(a[5:0]);
      w = {gold[b+3], gold[b+2], gold[b+1], gold[b]};
    end
    if (sz == 2'd0) begin
      v = int'(w & 32'hFF);
      if (sx && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = int'(w & 32'hFFFF);
      if (sx && v >= 32768) v -= 65536;
    end else return w;
    return 32'(v);
  endfunction

  function automatic logic exp_err(logic we, logic [31:0] a, logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a % 2 != 0) return 1'b1;
    if (sz == 2'd2 && a % 4 != 0) return 1'b1;
    if (a >= 64 && a != 128) return 1'b1;
    if (we && a < 32) return 1'b1;
    return 1'b0;
  endfunction

  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    req_sext  = 1'($urandom_range(0, 1));
  endtask

  // Drives one request from a negedge and records what the port did; ends one negedge after consumption.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sx);
    int n;
    obs_lat = -1; obs_pulses = 0; obs_err = 1'b0; obs_rdata = '0;
    obs_maddr = '0; obs_msize = '0; obs_szex = 1'b0; obs_rdy_resp = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_sext = sx;
    @(negedge clk);
    for (int l = 1; l <= 20; l++) begin
      if (mem_wr_en === 1'b1) obs_pulses++;
      if (l == 1) begin
        obs_maddr = mem_addr; obs_msize = mem_size; obs_szex = mem_sz_ex;
      end
      if (resp_valid === 1'b1) begin
        obs_lat = l; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
      scramble();
      @(negedge clk);
    end
    if (obs_lat < 0) return;
    scramble();
    resp_ready = 1'b1;
    obs_rdy_resp = req_ready;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0; req_sext = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if ({resp_valid, resp_err} !== 2'b00) begin failures++; $display("FAIL rst_resp got=%b%b exp=00", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    checks++; if ({mem_wr_en, mem_sz_ex, mem_size} !== 4'h0) begin failures++; $display("FAIL rst_mem_ctl got=%b%b%b exp=0000", mem_wr_en, mem_sz_ex, mem_size); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    init_gold();
  endtask

  task automatic test_store_load();
    run_txn(1'b1, 32'h28, 32'hDEADBEEF, 2'd2, 1'b0);
    gold_store(32'h28, 32'hDEADBEEF, 2'd2);
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL st_pulses got=%0d exp=1", obs_pulses); end
    checks++; if (obs_lat !== 1 + ML) begin failures++; $display("FAIL st_latency got=%0d exp=%0d", obs_lat, 1 + ML); end
    checks++; if ({obs_err, obs_rdata} !== 33'h0) begin failures++; $display("FAIL st_resp got=%b/%h exp=0/0", obs_err, obs_rdata); end
    checks++; if (obs_maddr !== 32'h28) begin failures++; $display("FAIL st_mem_addr got=%h exp=28", obs_maddr); end
    run_txn(1'b0, 32'h28, 32'h0, 2'd2, 1'b0);
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", obs_rdata); end
    checks++; if (obs_lat !== 1 + ML) begin failures++; $display("FAIL ld_latency got=%0d exp=%0d", obs_lat, 1 + ML); end
    checks++; if ({obs_err, 32'(obs_pulses)} !== 33'h0) begin failures++; $display("FAIL ld_err_pulses got=%b/%0d exp=0/0", obs_err, obs_pulses); end
    checks++; if ({obs_rdy_resp, req_ready} !== 2'b01) begin failures++; $display("FAIL ready_after_resp got=%b%b exp=01", obs_rdy_resp, req_ready); end
  endtask

  task automatic test_byte_sext();
    run_txn(1'b1, 32'h29, 32'hAAAA55F0, 2'd0, 1'b0); gold_store(32'h29, 32'hAAAA55F0, 2'd0);
    run_txn(1'b1, 32'h2A, 32'h12340000, 2'd1, 1'b0); gold_store(32'h2A, 32'h12340000, 2'd1);
    run_txn(1'b1, 32'h2C, 32'hFFFFFF00, 2'd0, 1'b0); gold_store(32'h2C, 32'hFFFFFF00, 2'd0);
    checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL sub_store_pulses got=%0d exp=1", obs_pulses); end
    run_txn(1'b0, 32'h29, 32'h0, 2'd0, 1'b1);
    checks++; if (obs_rdata !== 32'hFFFFFFF0) begin failures++; $display("FAIL byte_sext got=%h exp=fffffff0", obs_rdata); end
    run_txn(1'b0, 32'h29, 32'h0, 2'd0, 1'b0);
    checks++; if (obs_rdata !== 32'h000000F0) begin failures++; $display("FAIL byte_zext got=%h exp=000000f0", obs_rdata); end
    run_txn(1'b0, 32'h28, 32'h0, 2'd1, 1'b1);
    checks++; if (obs_rdata !== 32'hFFFFF0EF) begin failures++; $display("FAIL half_sext got=%h exp=fffff0ef", obs_rdata); end
    run_txn(1'b0, 32'h2A, 32'h0, 2'd1, 1'b1);
    checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL half_zero got=%h exp=0", obs_rdata); end
  endtask

  task automatic test_errors();
    logic [35:0] tbl [5];
    tbl = '{{1'b0, 1'b0, 2'd1, 32'h21}, {1'b0, 1'b1, 2'd2, 32'h10}, {1'b0, 1'b0, 2'd2, 32'h40},
            {1'b0, 1'b0, 2'd3, 32'h24}, {1'b0, 1'b1, 2'd2, 32'h22}};
    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i][34], tbl[i][31:0], $urandom | 32'h1, tbl[i][33:32], 1'b1);
      checks++;
      if (obs_err !== 1'b1 || obs_lat !== 1 || obs_pulses !== 0 || obs_rdata !== 32'h0) begin
        failures++;
        $display("FAIL err_case%0d got=err%b/lat%0d/wr%0d/%h exp=err1/lat1/wr0/0", i, obs_err, obs_lat, obs_pulses, obs_rdata);
      end
    end
  endtask

  task automatic test_io();
    run_txn(1'b1, 32'd128, 32'h12345678, 2'd0, 1'b1);
    gold_store(32'd128, 32'h12345678, 2'd0);
    checks++; if ({obs_msize, obs_szex} !== 3'b100) begin failures++; $display("FAIL io_size got=%b/%b exp=10/0", obs_msize, obs_szex); end
    checks++; if (obs_pulses !== 1 || obs_err !== 1'b0) begin failures++; $display("FAIL io_store got=wr%0d/err%b exp=wr1/err0", obs_pulses, obs_err); end
    run_txn(1'b0, 32'd128, 32'h0, 2'd2, 1'b0);
    checks++; if (obs_rdata !== 32'h12345678) begin failures++; $display("FAIL io_load got=%h exp=12345678", obs_rdata); end
    run_txn(1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    checks++; if ({obs_msize, obs_szex} !== 3'b100) begin failures++; $display("FAIL imem_size got=%b/%b exp=10/0", obs_msize, obs_szex); end
    checks++; if (obs_rdata !== exp_load(32'h13, 2'd0, 1'b1)) begin failures++; $display("FAIL imem_load got=%h exp=%h", obs_rdata, exp_load(32'h13, 2'd0, 1'b1)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r;
    int n;
    exp_r = exp_load(32'h28, 2'd2, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h28; req_size = 2'd2; req_sext = 1'b0;
    @(negedge clk);
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      scramble();
      @(negedge clk);
      n++;
    end
    checks++; if (resp_rdata !== exp_r) begin failures++; $display("FAIL bp_rdata got=%h exp=%h", resp_rdata, exp_r); end
    for (int k = 0; k < 5; k++) begin
      scramble();
      req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_r || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b/%h/rdy%b exp=v1/%h/rdy0", k, resp_valid, resp_rdata, req_ready, exp_r);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin failures++; $display("FAIL bp_release got=%b%b exp=10", req_ready, resp_valid); end
  endtask

  task automatic test_random();
    logic we, sx, e;
    logic [31:0] a, wd, exp_r;
    logic [1:0] sz;
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 7))
        0:       a = 32'd128;
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 71));
      endcase
      e = exp_err(we, a, sz);
      exp_r = (e || we) ? 32'h0 : exp_load(a, sz, sx);
      run_txn(we, a, wd, sz, sx);
      if (!e && we) gold_store(a, wd, sz);
      checks++;
      if (obs_err !== e || obs_lat !== (e ? 1 : 1 + ML) || obs_rdata !== exp_r || obs_pulses !== ((!e && we) ? 1 : 0)) begin
        failures++;
        $display("FAIL rnd%0d a=%h we%b sz%0d got=err%b/lat%0d/%h/wr%0d exp=err%b/lat%0d/%h/wr%0d", t, a, we, sz,
                 obs_err, obs_lat, obs_rdata, obs_pulses, e, e ? 1 : 1 + ML, exp_r, (!e && we) ? 1 : 0);
      end
      if (!e) begin
        checks++;
        if (obs_msize !== ((a == 32'd128 || a < 32) ? 2'd2 : sz) || obs_maddr !== a) begin
          failures++;
          $display("FAIL rnd%0d_mem got=%h/%0d exp=%h/%0d", t, obs_maddr, obs_msize, a, (a == 32'd128 || a < 32) ? 2'd2 : sz);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_size = 2'd2; req_sext = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h30 || resp_valid !== 1'b0) begin failures++; $display("FAIL mid_wait got=%h/v%b exp=30/v0", mem_addr, resp_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({req_ready, resp_valid} !== 2'b10 || mem_addr !== 32'h0) begin failures++; $display("FAIL wait_rst got=%b%b/%h exp=10/0", req_ready, resp_valid, mem_addr); end
    init_gold();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || mem_wr_en === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL ghost_resp got=%0d exp=0", seen); end
    run_txn(1'b0, 32'h30, 32'h0, 2'd2, 1'b0);
    checks++; if (obs_rdata !== exp_load(32'h30, 2'd2, 1'b0) || obs_lat !== 1 + ML) begin failures++; $display("FAIL post_rst_load got=%h/lat%0d exp=%h/lat%0d", obs_rdata, obs_lat, exp_load(32'h30, 2'd2, 1'b0), 1 + ML); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_sext();
    test_errors();
    test_io();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
